// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port data memory; read data returns one cycle after grant.
// Same-cycle req/ready grant with no response backpressure; optional DMEM_ARB_LOCK_EN adds bounded per-port locks.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 64,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              a_lock,
  input  logic              b_lock,
`endif
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, GNT_A, GNT_B
`ifdef DMEM_ARB_LOCK_EN
    , LOCK_A, LOCK_B
`endif
  } state_t;

  state_t state;
  logic   last_a, rr_a, rr_b, gnt_a, gnt_b;
  logic   a_oor, b_oor, sel_oor, sel_we;
  logic   a_rvalid_q, a_err_q, b_rvalid_q, b_err_q;

  if (LOCK_MAX < 1) begin : g_lock_max_check
    $error("LOCK_MAX must be at least 1");
  end

  assign a_oor = (a_addr >= ADDR_W'(DEPTH));
  assign b_oor = (b_addr >= ADDR_W'(DEPTH));

`ifdef DMEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_hold;
  assign last_a    = (state == GNT_A) || (state == LOCK_A);
  assign lock_hold = (state == LOCK_A) ? a_lock : b_lock;
`else
  assign last_a = (state == GNT_A);
`endif

  // IDLE counts as "B went last" so A wins the first tie after reset
  assign rr_a = a_req && (!b_req || !last_a);
  assign rr_b = b_req && (!a_req || last_a);

  always_comb begin
    gnt_a = rr_a;
    gnt_b = rr_b;
`ifdef DMEM_ARB_LOCK_EN
    if (state == LOCK_A) begin
      gnt_a = a_req;
      gnt_b = 1'b0;
    end else if (state == LOCK_B) begin
      gnt_a = 1'b0;
      gnt_b = b_req;
    end
`endif
    if (reset) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  assign a_ready   = gnt_a;
  assign b_ready   = gnt_b;
  assign sel_we    = gnt_a ? a_we  : b_we;
  assign sel_oor   = gnt_a ? a_oor : b_oor;
  assign mem_addr  = gnt_a ? a_addr  : (gnt_b ? b_addr  : '0);
  assign mem_wdata = gnt_a ? a_wdata : (gnt_b ? b_wdata : '0);
  assign mem_we    = (gnt_a || gnt_b) && !sel_oor && sel_we;
  assign mem_re    = (gnt_a || gnt_b) && !sel_oor && !sel_we;

  // A response still in flight when reset rises is suppressed immediately
  assign a_rvalid = a_rvalid_q && !reset;
  assign a_err    = a_err_q && !reset;
  assign b_rvalid = b_rvalid_q && !reset;
  assign b_err    = b_err_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      a_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      a_rdata    <= '0;
      b_rvalid_q <= 1'b0;
      b_err_q    <= 1'b0;
      b_rdata    <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt   <= '0;
`endif
    end else begin
      a_rvalid_q <= gnt_a;
      a_err_q    <= gnt_a && a_oor;
      if (gnt_a && a_oor)      a_rdata <= '0;
      else if (gnt_a && !a_we) a_rdata <= mem_rdata;
      b_rvalid_q <= gnt_b;
      b_err_q    <= gnt_b && b_oor;
      if (gnt_b && b_oor)      b_rdata <= '0;
      else if (gnt_b && !b_we) b_rdata <= mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
      // Leaving a lock lands in GNT_x so round-robin hands the next tie to the other port
      if (state == LOCK_A || state == LOCK_B) begin
        if (lock_hold && lock_cnt != CNT_W'(LOCK_MAX - 1)) begin
          lock_cnt <= lock_cnt + 1'b1;
        end else begin
          lock_cnt <= '0;
          state    <= (state == LOCK_A) ? GNT_A : GNT_B;
        end
      end else if (gnt_a) begin
        state <= a_lock ? LOCK_A : GNT_A;
      end else if (gnt_b) begin
        state <= b_lock ? LOCK_B : GNT_B;
      end
`else
      if (gnt_a)      state <= GNT_A;
      else if (gnt_b) state <= GNT_B;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory/arbiter model checked every cycle, plus directed literal checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        a_lock = 1'b0, b_lock = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
`ifdef DMEM_ARB_LOCK_EN
    .a_lock(a_lock), .b_lock(b_lock),
`endif
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Physical memory seen by the DUT
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] = mem_wdata;

  // Reference model state
  logic [31:0] ref_mem [64];
  logic        ref_last_a = 1'b0;
  logic        exp_a_rvalid = 1'b0, exp_a_err = 1'b0, exp_b_rvalid = 1'b0, exp_b_err = 1'b0;
  logic [31:0] exp_a_rdata = '0, exp_b_rdata = '0;
  logic        chk_en = 1'b0;
  int          n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // {grant_a, grant_b} from the round-robin rule
  function automatic logic [1:0] ref_grant();
    if (reset) return 2'b00;
    if (a_req && b_req) return ref_last_a ? 2'b01 : 2'b10;
    return {a_req, b_req};
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    g = ref_grant();
    if (reset) begin
      ref_last_a = 1'b0;
      exp_a_rvalid = 1'b0; exp_a_err = 1'b0; exp_a_rdata = '0;
      exp_b_rvalid = 1'b0; exp_b_err = 1'b0; exp_b_rdata = '0;
    end else begin
      exp_a_rvalid = g[1];
      exp_a_err    = g[1] && (a_addr >= 64);
      exp_b_rvalid = g[0];
      exp_b_err    = g[0] && (b_addr >= 64);
      if (g[1]) begin
        if (a_addr >= 64) exp_a_rdata = '0;
        else if (a_we)    ref_mem[a_addr] = a_wdata;
        else              exp_a_rdata = ref_mem[a_addr];
        ref_last_a = 1'b1;
      end else if (g[0]) begin
        if (b_addr >= 64) exp_b_rdata = '0;
        else if (b_we)    ref_mem[b_addr] = b_wdata;
        else              exp_b_rdata = ref_mem[b_addr];
        ref_last_a = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0]  g;
    logic [31:0] s_addr, s_wdata;
    logic        s_we, any;
    if (chk_en) begin
      g       = ref_grant();
      any     = |g;
      s_addr  = g[1] ? a_addr  : (g[0] ? b_addr  : 32'd0);
      s_wdata = g[1] ? a_wdata : (g[0] ? b_wdata : 32'd0);
      s_we    = g[1] ? a_we : b_we;
      check("a_ready",   {31'd0, a_ready}, {31'd0, g[1]});
      check("b_ready",   {31'd0, b_ready}, {31'd0, g[0]});
      check("mem_we",    {31'd0, mem_we}, {31'd0, any && s_we && (s_addr < 64)});
      check("mem_re",    {31'd0, mem_re}, {31'd0, any && !s_we && (s_addr < 64)});
      check("mem_addr",  mem_addr, s_addr);
      check("mem_wdata", mem_wdata, s_wdata);
      check("a_rvalid",  {31'd0, a_rvalid}, {31'd0, exp_a_rvalid && !reset});
      check("a_err",     {31'd0, a_err}, {31'd0, exp_a_err && !reset});
      check("a_rdata",   a_rdata, exp_a_rdata);
      check("b_rvalid",  {31'd0, b_rvalid}, {31'd0, exp_b_rvalid && !reset});
      check("b_err",     {31'd0, b_err}, {31'd0, exp_b_err && !reset});
      check("b_rdata",   b_rdata, exp_b_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic pa = 1'b0, pb = 1'b0;
  int   nb8, nb;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1; a_wdata = '0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2; b_wdata = '0;

    // Reset held with both ports requesting
    for (int i = 0; i < 3; i++) begin
      #2;
      check("rst_a_ready", {31'd0, a_ready}, 32'd0);
      check("rst_b_ready", {31'd0, b_ready}, 32'd0);
      check("rst_mem_we",  {31'd0, mem_we}, 32'd0);
      check("rst_mem_re",  {31'd0, mem_re}, 32'd0);
      tick();
      chk_en = 1'b1;
    end
    reset = 1'b0;

    // Continuous contention: A,B,A,B,A,B with responses one cycle later
    for (int i = 0; i < 6; i++) begin
      #2;
      check("rr_a_ready",  {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_b_ready",  {31'd0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_a_rvalid", {31'd0, a_rvalid}, (i > 0 && (i % 2 == 1)) ? 32'd1 : 32'd0);
      check("rr_b_rvalid", {31'd0, b_rvalid}, (i > 0 && (i % 2 == 0)) ? 32'd1 : 32'd0);
      tick();
    end

    // Write then read-back on port A
    b_req = 1'b0;
    a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'hDEADBEEF;
    #2;
    check("wr_a_ready", {31'd0, a_ready}, 32'd1);
    check("wr_mem_we",  {31'd0, mem_we}, 32'd1);
    tick();
    a_we = 1'b0;
    #2;
    check("wr_rsp_rvalid", {31'd0, a_rvalid}, 32'd1);
    check("wr_rsp_err",    {31'd0, a_err}, 32'd0);
    check("rd_mem_re",     {31'd0, mem_re}, 32'd1);
    tick();
    a_req = 1'b0;
    #2;
    check("rd_rvalid", {31'd0, a_rvalid}, 32'd1);
    check("rd_rdata",  a_rdata, 32'hDEADBEEF);
    check("rd_err",    {31'd0, a_err}, 32'd0);
    tick();

    // Out-of-range read on port B
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd64;
    #2;
    check("oor_b_ready", {31'd0, b_ready}, 32'd1);
    check("oor_mem_re",  {31'd0, mem_re}, 32'd0);
    check("oor_mem_we",  {31'd0, mem_we}, 32'd0);
    tick();
    b_req = 1'b0;
    #2;
    check("oor_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    check("oor_b_err",    {31'd0, b_err}, 32'd1);
    check("oor_b_rdata",  b_rdata, 32'd0);
    tick();

    // Reset right after an A read grant drops the response
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
    #2;
    check("rstrd_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    reset = 1'b1; a_req = 1'b0;
    #2;
    check("rstrd_rvalid", {31'd0, a_rvalid}, 32'd0);
    tick();
    reset = 1'b0;
    #2;
    check("rstrd_rdata",   a_rdata, 32'd0);
    check("rstrd_rvalid2", {31'd0, a_rvalid}, 32'd0);
    tick();

    // Randomized traffic; a request not yet granted is held stable
    for (int c = 0; c < 800; c++) begin
      if (!pa) begin
        a_req = ($urandom_range(0, 2) != 0); a_we = $urandom_range(0, 1);
        a_addr = $urandom_range(0, 70); a_wdata = $urandom;
      end
      if (!pb) begin
        b_req = ($urandom_range(0, 2) != 0); b_we = $urandom_range(0, 1);
        b_addr = $urandom_range(0, 70); b_wdata = $urandom;
      end
      reset = ($urandom_range(0, 60) == 0);
      #2;
      pa = a_req && !a_ready;
      pb = b_req && !b_ready;
      tick();
    end
    reset = 1'b0;

`ifdef DMEM_ARB_LOCK_EN
    chk_en = 1'b0;
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
    tick();
    reset = 1'b0;
    a_req = 1'b1; a_lock = 1'b1; a_we = 1'b0; a_addr = 32'd3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd4;
    nb8 = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (b_ready) begin
        nb++;
        if (i < 8) nb8++;
      end
      tick();
    end
    check("lock_b_blocked",   nb8, 32'd0);
    check("lock_b_one_grant", nb, 32'd1);
    a_lock = 1'b0; a_req = 1'b0; b_req = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
